// File: rtl/axil_pkg.sv
// Shared types and response codes for the AXI4-Lite write-only register bank.
package axil_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_W,
    WAIT_A,
    RESP
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_wr_ctrl.sv
// AXI4-Lite write channel FSM: joins AW/W in either order and issues one write + B response.
// Optional byte strobes are enabled with the AXIL_WSTRB_EN macro.
module axil_wr_ctrl #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS           = 4,
  localparam int unsigned IDX_W             = C_S_AXI_ADDR_WIDTH - 2,
  localparam int unsigned STRB_W            = C_S_AXI_DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_i,
`ifdef AXIL_WSTRB_EN
  input  logic [STRB_W-1:0]             wstrb_i,
`endif
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  output logic                          wr_en_o,
  output logic [IDX_W-1:0]              wr_idx_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_o,
  output logic [STRB_W-1:0]             wr_strb_o
);
  import axil_pkg::*;

  wr_state_e                     state_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
`ifdef AXIL_WSTRB_EN
  logic [STRB_W-1:0]             wstrb_q;
`endif

  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_sel;
  logic [IDX_W-1:0]              idx;
  logic                          in_range;
  logic                          complete;
  logic                          unused_addr_lsb;

  // The second handshake uses the live bus for that channel and the latched copy for the other.
  always_comb begin
    addr_sel = (state_q == WAIT_W) ? awaddr_q : awaddr_i;
    idx      = addr_sel[C_S_AXI_ADDR_WIDTH-1:2];
    in_range = {1'b0, idx} < (IDX_W + 1)'(NUM_REGS);
    complete = 1'b0;
    case (state_q)
      IDLE:    complete = awvalid_i && wvalid_i;
      WAIT_W:  complete = wvalid_i;
      WAIT_A:  complete = awvalid_i;
      default: complete = 1'b0;
    endcase
    complete = complete && !rst_i;
  end

  assign unused_addr_lsb = ^addr_sel[1:0];

  assign awready_o = !rst_i && (state_q == IDLE || state_q == WAIT_A);
  assign wready_o  = !rst_i && (state_q == IDLE || state_q == WAIT_W);
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

  assign wr_en_o   = complete && in_range;
  assign wr_idx_o  = idx;
  assign wr_data_o = (state_q == WAIT_A) ? wdata_q : wdata_i;
`ifdef AXIL_WSTRB_EN
  assign wr_strb_o = (state_q == WAIT_A) ? wstrb_q : wstrb_i;
`else
  assign wr_strb_o = '1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
`ifdef AXIL_WSTRB_EN
      wstrb_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, WAIT_W, WAIT_A: begin
          if (complete) begin
            state_q  <= RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
          end else if (state_q == IDLE && awvalid_i) begin
            awaddr_q <= awaddr_i;
            state_q  <= WAIT_W;
          end else if (state_q == IDLE && wvalid_i) begin
            wdata_q  <= wdata_i;
`ifdef AXIL_WSTRB_EN
            wstrb_q  <= wstrb_i;
`endif
            state_q  <= WAIT_A;
          end
        end
        RESP: begin
          if (bready_i) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_wr_regbank.sv
// AXI4-Lite write-only register bank with flattened register outputs and per-register update strobes.
// Define AXIL_WSTRB_EN to add the s_wstrb port and byte-lane masking.
module axil_wr_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   s_aclk,
  input  logic                                   s_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                             s_awprot,
  input  logic                                   s_awvalid,
  output logic                                   s_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_wdata,
`ifdef AXIL_WSTRB_EN
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_wstrb,
`endif
  input  logic                                   s_wvalid,
  output logic                                   s_wready,
  output logic [1:0]                             s_bresp,
  output logic                                   s_bvalid,
  input  logic                                   s_bready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]                    wr_pulse
);
  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned STRB_W = DW / 8;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [DW-1:0]       wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic                unused_awprot;

  assign unused_awprot = ^s_awprot;

  axil_wr_ctrl #(
    .C_S_AXI_DATA_WIDTH(C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH(C_S_AXI_ADDR_WIDTH),
    .NUM_REGS          (NUM_REGS)
  ) u_ctrl (
    .clk_i    (s_aclk),
    .rst_i    (s_areset),
    .awaddr_i (s_awaddr),
    .awvalid_i(s_awvalid),
    .awready_o(s_awready),
    .wdata_i  (s_wdata),
`ifdef AXIL_WSTRB_EN
    .wstrb_i  (s_wstrb),
`endif
    .wvalid_i (s_wvalid),
    .wready_o (s_wready),
    .bresp_o  (s_bresp),
    .bvalid_o (s_bvalid),
    .bready_i (s_bready),
    .wr_en_o  (wr_en),
    .wr_idx_o (wr_idx),
    .wr_data_o(wr_data),
    .wr_strb_o(wr_strb)
  );

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        wr_pulse_q[i] <= wr_en && (wr_idx == IDX_W'(i));
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_out[i*DW +: DW] = regs_q[i];
  end

  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axil_wr_regbank.sv
// Directed bench for axil_wr_regbank: a 4-register and a 3-register instance share one stimulus bus.
module tb_axil_wr_regbank;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          s_aclk = 1'b0;
  logic          s_areset;
  logic [AW-1:0] s_awaddr;
  logic [2:0]    s_awprot;
  logic          s_awvalid;
  logic [DW-1:0] s_wdata;
`ifdef AXIL_WSTRB_EN
  logic [DW/8-1:0] s_wstrb;
`endif
  logic          s_wvalid;
  logic          s_bready;

  logic          awready4, wready4, bvalid4;
  logic [1:0]    bresp4;
  logic [127:0]  regs4;
  logic [3:0]    pulse4;
  logic          awready3, wready3, bvalid3;
  logic [1:0]    bresp3;
  logic [95:0]   regs3;
  logic [2:0]    pulse3;

  logic [31:0]   exp4 [4];
  logic [31:0]   exp3 [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 s_aclk = ~s_aclk;

  axil_wr_regbank dut4 (
    .s_aclk(s_aclk), .s_areset(s_areset), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(awready4), .s_wdata(s_wdata),
`ifdef AXIL_WSTRB_EN
    .s_wstrb(s_wstrb),
`endif
    .s_wvalid(s_wvalid), .s_wready(wready4), .s_bresp(bresp4), .s_bvalid(bvalid4),
    .s_bready(s_bready), .regs_out(regs4), .wr_pulse(pulse4)
  );

  axil_wr_regbank #(.NUM_REGS(3)) dut3 (
    .s_aclk(s_aclk), .s_areset(s_areset), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(awready3), .s_wdata(s_wdata),
`ifdef AXIL_WSTRB_EN
    .s_wstrb(s_wstrb),
`endif
    .s_wvalid(s_wvalid), .s_wready(wready3), .s_bresp(bresp3), .s_bvalid(bvalid3),
    .s_bready(s_bready), .regs_out(regs3), .wr_pulse(pulse3)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_aclk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, " regs4"}, regs4, {exp4[3], exp4[2], exp4[1], exp4[0]});
    chk({tag, " regs3"}, regs3, {exp3[2], exp3[1], exp3[0]});
  endtask

  // Both channels valid in the same cycle; returns just after the accepting edge.
  task automatic write_both(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    s_awaddr  = addr;
    s_wdata   = data;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic ack(input string tag);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk({tag, " bvalid4 after ack"}, bvalid4, 1'b0);
    chk({tag, " bvalid3 after ack"}, bvalid3, 1'b0);
    chk({tag, " bresp4 after ack"}, bresp4, 2'b00);
  endtask

  initial begin
    s_areset  = 1'b1;
    s_awaddr  = '0;
    s_awprot  = 3'b010;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
`ifdef AXIL_WSTRB_EN
    s_wstrb   = '1;
`endif
    for (int i = 0; i < 4; i++) exp4[i] = '0;
    for (int i = 0; i < 3; i++) exp3[i] = '0;

    tick();
    tick();
    chk("rst awready", awready4, 1'b0);
    chk("rst wready", wready4, 1'b0);
    chk("rst bvalid", bvalid4, 1'b0);
    chk("rst bresp", bresp4, 2'b00);
    chk("rst pulse", pulse4, 4'b0000);
    chk_regs("rst");
    s_areset = 1'b0;
    #1;
    chk("idle awready", awready4, 1'b1);
    chk("idle wready", wready4, 1'b1);
    tick();

    // Simultaneous AW+W to reg1
    write_both(4'h4, 32'hDEADBEEF);
    exp4[1] = 32'hDEADBEEF;
    exp3[1] = 32'hDEADBEEF;
    chk_regs("t1");
    chk("t1 pulse4", pulse4, 4'b0010);
    chk("t1 pulse3", pulse3, 3'b010);
    chk("t1 bvalid", bvalid4, 1'b1);
    chk("t1 bresp", bresp4, 2'b00);
    chk("t1 awready", awready4, 1'b0);
    chk("t1 wready", wready4, 1'b0);
    tick();
    chk("t1 pulse one cycle", pulse4, 4'b0000);
    chk("t1 bvalid held", bvalid4, 1'b1);
    ack("t1");

    // W three cycles ahead of AW; W bus changes after its handshake
    s_wdata  = 32'h12345678;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    s_wdata  = 32'hFFFF0000;
    chk("t2 wready drop", wready4, 1'b0);
    chk("t2 awready", awready4, 1'b1);
    chk("t2 bvalid early", bvalid4, 1'b0);
    chk("t2 pulse early", pulse4, 4'b0000);
    tick();
    tick();
    s_awaddr  = 4'h8;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    exp4[2] = 32'h12345678;
    exp3[2] = 32'h12345678;
    chk_regs("t2");
    chk("t2 pulse4", pulse4, 4'b0100);
    chk("t2 bvalid", bvalid4, 1'b1);
    chk("t2 bresp", bresp4, 2'b00);
    ack("t2");

    // Index 3: last valid word on the 4-reg bank, out of range on the 3-reg bank
    write_both(4'hC, 32'hA5A5A5A5);
    exp4[3] = 32'hA5A5A5A5;
    chk_regs("t3");
    chk("t3 pulse4", pulse4, 4'b1000);
    chk("t3 pulse3", pulse3, 3'b000);
    chk("t3 bresp4", bresp4, 2'b00);
    chk("t3 bresp3", bresp3, 2'b10);
    chk("t3 bvalid3", bvalid3, 1'b1);

    // Backpressure on B with new traffic offered; nothing may be accepted
    s_awaddr  = 4'h0;
    s_wdata   = 32'h11111111;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4 bvalid3 held", bvalid3, 1'b1);
      chk("t4 bresp3 held", bresp3, 2'b10);
      chk("t4 awready", awready3, 1'b0);
      chk("t4 wready", wready3, 1'b0);
      chk("t4 pulse3", pulse3, 3'b000);
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk_regs("t4");
    ack("t4");
    tick();
    chk("t4 single resp", bvalid3, 1'b0);
    chk("t4 single resp4", bvalid4, 1'b0);

    // AW first, address bus changes after its handshake
    s_awaddr  = 4'h1;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_awaddr  = 4'h8;
    chk("t5 awready drop", awready4, 1'b0);
    chk("t5 wready", wready4, 1'b1);
    chk("t5 bvalid early", bvalid4, 1'b0);
    s_wdata  = 32'h0BADF00D;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    exp4[0] = 32'h0BADF00D;
    exp3[0] = 32'h0BADF00D;
    chk_regs("t5");
    chk("t5 pulse4", pulse4, 4'b0001);
    chk("t5 bresp", bresp4, 2'b00);
    ack("t5");

    // Reset after AW, before W: latched address must be dropped
    s_awaddr  = 4'h4;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_areset  = 1'b1;
    #1;
    chk("t6 awready in rst", awready4, 1'b0);
    chk("t6 wready in rst", wready4, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) exp4[i] = '0;
    for (int i = 0; i < 3; i++) exp3[i] = '0;
    chk_regs("t6 rst");
    chk("t6 bvalid", bvalid4, 1'b0);
    chk("t6 pulse", pulse4, 4'b0000);
    s_areset = 1'b0;
    #1;
    chk("t6 idle awready", awready4, 1'b1);
    chk("t6 idle wready", wready4, 1'b1);
    s_wdata  = 32'hCAFEF00D;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("t6 no stale resp", bvalid4, 1'b0);
    chk("t6 no stale pulse", pulse4, 4'b0000);
    chk("t6 wait_a awready", awready4, 1'b1);
    s_awaddr  = 4'hB;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    exp4[2] = 32'hCAFEF00D;
    exp3[2] = 32'hCAFEF00D;
    chk_regs("t6");
    chk("t6 pulse4", pulse4, 4'b0100);
    chk("t6 bvalid", bvalid4, 1'b1);
    ack("t6");

`ifdef AXIL_WSTRB_EN
    s_wstrb = 4'b1111;
    write_both(4'h0, 32'hFFFFFFFF);
    ack("t7a");
    s_wstrb = 4'b0101;
    write_both(4'h0, 32'h00000000);
    exp4[0] = 32'hFF00FF00;
    exp3[0] = 32'hFF00FF00;
    chk_regs("t7 strb");
    chk("t7 pulse", pulse4, 4'b0001);
    ack("t7b");
    s_wstrb = 4'b0000;
    write_both(4'h0, 32'h12345678);
    chk_regs("t7 strb0");
    chk("t7 strb0 pulse", pulse4, 4'b0001);
    chk("t7 strb0 bresp", bresp4, 2'b00);
    ack("t7c");
    s_wstrb = 4'b1111;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_wr_regbank.md
AXIL_WR_REGBANK -- requirements
Module: axil_wr_regbank

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning data bus width in bits (multiple of 8).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, meaning byte address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 4, meaning implemented 32-bit words (1 to 2^(C_S_AXI_ADDR_WIDTH-2)).
REQ-004 The block SHALL have port s_aclk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port s_areset, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have port s_awaddr, input, C_S_AXI_ADDR_WIDTH, meaning write address.
REQ-007 The block SHALL have port s_awprot, input, 3, meaning protection bits (accepted, ignored).
REQ-008 The block SHALL have ports s_awvalid (input, 1) and s_awready (output, 1), meaning the AW handshake.
REQ-009 The block SHALL have port s_wdata, input, C_S_AXI_DATA_WIDTH, meaning write data.
REQ-010 The block SHALL have ports s_wvalid (input, 1) and s_wready (output, 1), meaning the W handshake.
REQ-011 The block SHALL have port s_bresp, output, 2, meaning the write response.
REQ-012 The block SHALL have ports s_bvalid (output, 1) and s_bready (input, 1), meaning the B handshake.
REQ-013 The block SHALL have port regs_out, output, NUM_REGS*C_S_AXI_DATA_WIDTH, meaning flattened register contents, reg i at bits [i*W +: W].
REQ-014 The block SHALL have port wr_pulse, output, NUM_REGS, meaning a one-cycle strobe per register on update.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_W (address held), WAIT_A (data held) and RESP.
REQ-016 s_awready SHALL be 1 in IDLE and WAIT_A only; s_wready SHALL be 1 in IDLE and WAIT_W only.
REQ-017 In IDLE: both valids go to RESP; s_awvalid only goes to WAIT_W; s_wvalid only goes to WAIT_A; neither stays in IDLE.
REQ-018 WAIT_W SHALL go to RESP on s_wvalid, and WAIT_A SHALL go to RESP on s_awvalid.
REQ-019 The address/data accepted in a handshake SHALL be latched; later input changes SHALL be ignored.
REQ-020 The write index SHALL be addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] SHALL be ignored.
REQ-021 The register write and wr_pulse SHALL take effect at the edge completing the second handshake; s_bvalid SHALL be 1 from the next cycle (latency 1).
REQ-022 Index < NUM_REGS SHALL write the register and give s_bresp=2'b00 (OKAY).
REQ-023 Index >= NUM_REGS SHALL write nothing, pulse nothing and give s_bresp=2'b10 (SLVERR).
REQ-024 In RESP, s_bvalid and s_bresp SHALL hold until s_bready=1, and no AW/W SHALL be accepted.
REQ-025 When s_bvalid&&s_bready, the FSM SHALL return to IDLE, and the next transaction SHALL be accepted no earlier than the following cycle.
REQ-026 s_bresp SHALL be 2'b00 whenever s_bvalid=0.

Reset
REQ-027 With s_areset=1 at an edge, the FSM SHALL go to IDLE and all registers, wr_pulse, s_bvalid and s_bresp SHALL be 0.
REQ-028 A reset mid-transaction SHALL discard any latched address/data with no write and no response.
REQ-029 s_awready and s_wready SHALL be 0 while s_areset=1.

Configuration
REQ-030 With AXIL_WSTRB_EN defined, the block SHALL add input s_wstrb of width C_S_AXI_DATA_WIDTH/8, latched with W, and update only byte lanes whose strobe bit is 1.
REQ-031 With s_wstrb=0 on an in-range address, the response SHALL be OKAY, the register SHALL be unchanged and wr_pulse SHALL still fire.
REQ-032 Without AXIL_WSTRB_EN, there SHALL be no s_wstrb port and every write SHALL update the full word.

Structure
REQ-033 A package axil_pkg SHALL hold the FSM state enum and the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-034 The FSM and handshake logic SHALL be in a sub-module axil_wr_ctrl, which outputs the write enable, index and data; the register array SHALL stay at top level.

Verification
REQ-035 After reset, awaddr=0x4 with wdata=0xDEADBEEF, both valid in the same cycle -> reg1=0xDEADBEEF, wr_pulse=4'b0010 for one cycle, bvalid the next cycle, bresp=00.
REQ-036 W sent 3 cycles before AW (awaddr=0x8, wdata=0x12345678) -> wready drops after the W handshake, then reg2=0x12345678 and bresp=00.
REQ-037 With NUM_REGS=3, write awaddr=0xC -> bresp=10, no register changes, wr_pulse stays 0.
REQ-038 bready held low for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout, then a single response completes.
REQ-039 AW accepted, then reset before W -> no write, no bvalid, FSM in IDLE.
REQ-040 With AXIL_WSTRB_EN, reg0=0xFFFFFFFF and a write of 0x00000000 with wstrb=4'b0101 -> reg0=0xFF00FF00.
